serdes_tx_serializer: RTL and testbench
=======================================

# serdes_tx_serializer

Serial transmitter for the SerDes link: accepts parallel bytes over a valid/ready handshake and shifts them out LSB first, one bit per clock, on a single serial line with a frame strobe. It is the transmit end of the link whose deserializer consumes one bit per cycle on `ui_in[0]`. It sits between the on-chip byte source and the `uo_out` pin mapping in the Tiny Tapeout top level.

## Interface
Parameters:
- `DATA_W`, 8: bits per frame payload.
- `GAP`, 0: minimum idle cycles inserted between consecutive frames (0..15).

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ena` in 1: block enable; low freezes all state.
- `tx_data` in DATA_W: byte to send, sampled on accept.
- `tx_valid` in 1: source has a byte.
- `tx_ready` out 1: holding register empty; accept = `tx_valid && tx_ready` at rising edge.
- `ser_out` out 1: serial data, LSB first.
- `ser_frame` out 1: high during the cycle carrying bit 0 of a frame.
- `ser_busy` out 1: high in every cycle a frame bit (or parity bit) is on `ser_out`.

## Operation
- Datapath: 1-entry holding register (`hold`, `hold_valid`) feeding a DATA_W shift register; bit counter `$clog2(DATA_W+1)` wide; gap counter 4 bits.
- `tx_ready = ena && !hold_valid` (combinational from registered state).
- Accept: `hold <= tx_data`, `hold_valid <= 1`.
- FSM states: IDLE, SHIFT, PARITY (only with macro), GAP.
  - IDLE: `ser_out=0`, `ser_busy=0`. If `hold_valid`: load shift register from `hold`, clear `hold_valid`, counter=0, go SHIFT.
  - SHIFT: drive `shreg[0]`, shift right each cycle, counter++. After bit DATA_W-1: go PARITY if enabled; else GAP if `GAP>0`; else load next byte directly if `hold_valid` (stay SHIFT, no idle bit) or go IDLE.
  - PARITY: one cycle driving parity bit, then same exit rule as end of SHIFT.
  - GAP: `ser_out=0`, `ser_busy=0` for exactly GAP cycles, then IDLE.
- Transfer hold→shreg and accept never coincide: accept requires `hold_valid=0`; new accept possible the cycle after transfer, while shifting.
- `ena=0`: FSM, counters, shift register and outputs hold current values; `tx_ready=0`; `tx_valid` ignored.
- Reset (any time, including mid-frame): partial frame and held byte discarded, FSM to IDLE.

## Timing
- Reset values: `ser_out=0`, `ser_frame=0`, `ser_busy=0`, `hold_valid=0` (so `tx_ready=ena`), FSM IDLE.
- `ser_out`, `ser_frame`, `ser_busy` are registered.
- Latency from idle: accept at edge N → bit 0 on `ser_out` with `ser_frame=1` in the cycle after edge N+2 (edge N+1 moves hold→shreg, N+2 registers bit 0).
- Frame length: DATA_W cycles (DATA_W+1 with parity), `ser_busy` high throughout.
- GAP=0 with `hold_valid` at final bit: next frame bit 0 follows in the immediately next cycle; streaming throughput one bit per clock, no dead cycles.
- GAP>0: exactly GAP low/not-busy cycles plus one IDLE cycle between frames.

## Configuration
- `SERDES_TX_PARITY_EN` defined: PARITY state compiled in; after bit DATA_W-1 one extra bit = even parity (XOR of payload); frame is DATA_W+1 cycles.
- Undefined: no PARITY state, frames exactly DATA_W bits, bit-stream identical to raw payload.

## Test plan
- Send 0xA5 from idle, GAP=0 → `ser_out` = 1,0,1,0,0,1,0,1 on 8 consecutive cycles, `ser_frame` high only on first, `ser_busy` high for 8 cycles, first bit 2 cycles after accept edge.
- Back-to-back 0x00 then 0xFF with `tx_valid` held high → 16 continuous busy cycles: eight 0s then eight 1s, `ser_frame` pulses 8 cycles apart.
- GAP=2, two bytes 0x81, 0x81 → frames separated by 3 cycles with `ser_busy=0`, `ser_out=0`.
- With `SERDES_TX_PARITY_EN`: send 0x07 → 1,1,1,0,0,0,0,0 then parity 1; send 0x03 → parity 0; frames 9 cycles.
- Assert `rst_n=0` after bit 3 of 0xF0 with a second byte held → all outputs 0 immediately, `tx_ready=1` after release, no residual bits emitted.
- Deassert `ena` for 5 cycles mid-frame of 0x5A → `ser_out` frozen, `tx_ready=0`; on re-enable remaining bits resume with no loss or duplication.

Source files
------------

// File: rtl/serdes_tx_serializer.sv
// ============================================================================
// Module   : serdes_tx_serializer
// Brief    : Byte-to-serial transmitter. Bytes arrive on a valid/ready
//            handshake and leave LSB first, one bit per clock, with a frame
//            strobe on bit 0. Build macro SERDES_TX_PARITY_EN appends an even
//            parity bit to every frame.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serdes_tx_serializer #(
    parameter int DATA_W = 8,
    parameter int GAP    = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              ser_out,
    output logic              ser_frame,
    output logic              ser_busy
);

    localparam int                 c_CNT_W    = $clog2(DATA_W + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DATA_W - 1);
    localparam logic [3:0]         c_GAP_LAST = 4'((GAP > 0) ? GAP - 1 : 0);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SHIFT  = 2'd1;
    localparam logic [1:0] c_GAP    = 2'd3;
`ifdef SERDES_TX_PARITY_EN
    localparam logic [1:0] c_PARITY = 2'd2;
`endif

    logic [1:0]         r_state;
    logic [DATA_W-1:0]  r_hold;
    logic               r_hold_valid;
    logic [DATA_W-1:0]  r_shreg;
    logic [c_CNT_W-1:0] r_cnt;
    logic [3:0]         r_gap_cnt;
    logic               r_ser_out;
    logic               r_ser_frame;
    logic               r_ser_busy;
`ifdef SERDES_TX_PARITY_EN
    logic               r_parity;
`endif

    logic [1:0] w_state_nxt;
    logic [1:0] w_exit_state;
    logic       w_exit_load;
    logic       w_load;
    logic       w_shift;
    logic       w_gap_inc;
    logic       w_out_bit;
    logic       w_frame;
    logic       w_busy;

    assign tx_ready  = ena && !r_hold_valid;
    assign ser_out   = r_ser_out;
    assign ser_frame = r_ser_frame;
    assign ser_busy  = r_ser_busy;

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_gap_inc   = 1'b0;
        w_out_bit   = 1'b0;
        w_frame     = 1'b0;
        w_busy      = 1'b0;

        // Common end-of-frame exit: gap, back-to-back reload, or idle.
        w_exit_load = 1'b0;
        if (GAP > 0) begin
            w_exit_state = c_GAP;
        end else if (r_hold_valid) begin
            w_exit_state = c_SHIFT;
            w_exit_load  = 1'b1;
        end else begin
            w_exit_state = c_IDLE;
        end

        case (r_state)
            c_IDLE: begin
                if (r_hold_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = c_SHIFT;
                end
            end
            c_SHIFT: begin
                w_out_bit = r_shreg[0];
                w_frame   = (r_cnt == '0);
                w_busy    = 1'b1;
                w_shift   = 1'b1;
                if (r_cnt == c_CNT_LAST) begin
`ifdef SERDES_TX_PARITY_EN
                    w_state_nxt = c_PARITY;
`else
                    w_state_nxt = w_exit_state;
                    w_load      = w_exit_load;
`endif
                end
            end
`ifdef SERDES_TX_PARITY_EN
            c_PARITY: begin
                w_out_bit   = r_parity;
                w_busy      = 1'b1;
                w_state_nxt = w_exit_state;
                w_load      = w_exit_load;
            end
`endif
            c_GAP: begin
                w_gap_inc = 1'b1;
                if (r_gap_cnt == c_GAP_LAST) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_IDLE;
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_shreg      <= '0;
            r_cnt        <= '0;
            r_gap_cnt    <= '0;
            r_ser_out    <= 1'b0;
            r_ser_frame  <= 1'b0;
            r_ser_busy   <= 1'b0;
`ifdef SERDES_TX_PARITY_EN
            r_parity     <= 1'b0;
`endif
        end else if (ena) begin
            r_state     <= w_state_nxt;
            r_ser_out   <= w_out_bit;
            r_ser_frame <= w_frame;
            r_ser_busy  <= w_busy;

            // A reload on the last bit takes priority over the shift.
            if (w_load) begin
                r_shreg  <= r_hold;
                r_cnt    <= '0;
`ifdef SERDES_TX_PARITY_EN
                r_parity <= ^r_hold;
`endif
            end else if (w_shift) begin
                r_shreg <= r_shreg >> 1;
                r_cnt   <= r_cnt + c_CNT_W'(1);
            end

            if (w_gap_inc) begin
                r_gap_cnt <= r_gap_cnt + 4'd1;
            end else begin
                r_gap_cnt <= '0;
            end

            if (w_load) begin
                r_hold_valid <= 1'b0;
            end else if (tx_valid && tx_ready) begin
                r_hold       <= tx_data;
                r_hold_valid <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serdes_tx_serializer.sv
// ============================================================================
// Module   : tb_serdes_tx_serializer
// Brief    : Directed bench for serdes_tx_serializer (GAP=0 and GAP=2
//            instances); follows SERDES_TX_PARITY_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_serdes_tx_serializer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] tx_data, tx_data_g;
    logic       tx_valid, tx_valid_g;
    logic       tx_ready, ser_out, ser_frame, ser_busy;
    logic       tx_ready_g, ser_out_g, ser_frame_g, ser_busy_g;
    logic       use_g;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    serdes_tx_serializer #(.DATA_W(8), .GAP(0)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .ser_out(ser_out), .ser_frame(ser_frame), .ser_busy(ser_busy)
    );

    serdes_tx_serializer #(.DATA_W(8), .GAP(2)) dut_g (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .tx_data(tx_data_g), .tx_valid(tx_valid_g), .tx_ready(tx_ready_g),
        .ser_out(ser_out_g), .ser_frame(ser_frame_g), .ser_busy(ser_busy_g)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_bit(input logic [7:0] d, input int i);
        check("ser_out",   use_g ? ser_out_g   : ser_out,   32'(d[i]));
        check("ser_frame", use_g ? ser_frame_g : ser_frame, (i == 0) ? 32'd1 : 32'd0);
        check("ser_busy",  use_g ? ser_busy_g  : ser_busy,  32'd1);
    endtask

    task automatic check_par(input logic p);
        check("parity_out",   use_g ? ser_out_g   : ser_out,   32'(p));
        check("parity_frame", use_g ? ser_frame_g : ser_frame, 32'd0);
        check("parity_busy",  use_g ? ser_busy_g  : ser_busy,  32'd1);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_out"},   use_g ? ser_out_g   : ser_out,   32'd0);
        check({tag, "_frame"}, use_g ? ser_frame_g : ser_frame, 32'd0);
        check({tag, "_busy"},  use_g ? ser_busy_g  : ser_busy,  32'd0);
    endtask

    // Entered on the negedge showing bit 0; leaves on the last bit's negedge.
    task automatic expect_frame(input logic [7:0] d, input logic p);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            check_bit(d, i);
        end
`ifdef SERDES_TX_PARITY_EN
        @(negedge clk);
        check_par(p);
`else
        if (p === 1'bx) check("parity_arg", 32'(p), 32'd0);
`endif
    endtask

    task automatic drive(input logic v, input logic [7:0] d);
        if (use_g) begin
            tx_valid_g = v; tx_data_g = d;
        end else begin
            tx_valid = v; tx_data = d;
        end
    endtask

    // Single byte from idle; returns on the negedge carrying bit 0.
    task automatic start_one(input logic [7:0] d);
        drive(1'b1, d);
        @(negedge clk);
        drive(1'b0, 8'h00);
        check_idle("lat1");
        @(negedge clk);
        check_idle("lat2");
        @(negedge clk);
    endtask

    // Two bytes with valid held; returns on the negedge carrying bit 0 of a.
    task automatic start_pair(input logic [7:0] a, input logic [7:0] b);
        drive(1'b1, a);
        @(negedge clk);
        drive(1'b1, b);
        check("ready_full", use_g ? tx_ready_g : tx_ready, 32'd0);
        @(negedge clk);
        check("ready_xfer", use_g ? tx_ready_g : tx_ready, 32'd1);
        @(negedge clk);
        drive(1'b0, 8'h00);
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; use_g = 1'b0;
        tx_data = 8'h00; tx_valid = 1'b0; tx_data_g = 8'h00; tx_valid_g = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("rst");
        check("rst_ready", tx_ready, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Single byte 0xA5
        start_one(8'hA5);
        expect_frame(8'hA5, 1'b0);
        @(negedge clk);
        check_idle("a5_end");
        repeat (2) @(negedge clk);

        // Back-to-back 0x00 then 0xFF, no dead cycle
        start_pair(8'h00, 8'hFF);
        expect_frame(8'h00, 1'b0);
        @(negedge clk);
        expect_frame(8'hFF, 1'b0);
        @(negedge clk);
        check_idle("b2b_end");
        repeat (2) @(negedge clk);

        // Parity-sensitive payloads
        start_one(8'h07);
        expect_frame(8'h07, 1'b1);
        @(negedge clk);
        check_idle("p07_end");
        @(negedge clk);
        start_one(8'h03);
        expect_frame(8'h03, 1'b0);
        @(negedge clk);
        check_idle("p03_end");
        repeat (2) @(negedge clk);

        // GAP=2 instance: three quiet cycles between frames
        use_g = 1'b1;
        start_pair(8'h81, 8'h81);
        expect_frame(8'h81, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle("gap");
        end
        @(negedge clk);
        expect_frame(8'h81, 1'b0);
        @(negedge clk);
        check_idle("gap_end");
        use_g = 1'b0;
        repeat (4) @(negedge clk);

        // Enable drop for 5 cycles after bit 2 of 0x5A
        start_one(8'h5A);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            check_bit(8'h5A, i);
        end
        ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("frz_out", ser_out, 32'd0);
            check("frz_busy", ser_busy, 32'd1);
            check("frz_ready", tx_ready, 32'd0);
        end
        ena = 1'b1;
        for (int i = 3; i < 8; i++) begin
            @(negedge clk);
            check_bit(8'h5A, i);
        end
`ifdef SERDES_TX_PARITY_EN
        @(negedge clk);
        check_par(1'b0);
`endif
        @(negedge clk);
        check_idle("ena_end");
        repeat (2) @(negedge clk);

        // Reset after bit 3 of 0xF0 with 0x3C held
        start_pair(8'hF0, 8'h3C);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            check_bit(8'hF0, i);
        end
        rst_n = 1'b0;
        #1;
        check_idle("arst");
        check("arst_ready", tx_ready, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", tx_ready, 32'd1);
        for (int i = 0; i < 12; i++) begin
            check_idle("no_residue");
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
